// File: rtl/mips_mem_pkg.sv
// Shared types, size encodings and store-formatting helpers for the MEM stage.
package mips_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } mem_state_t;

   localparam logic [1:0] SIZE_BYTE     = 2'b00;
   localparam logic [1:0] SIZE_HALF     = 2'b01;
   localparam logic [1:0] SIZE_WORD     = 2'b10;
   localparam logic [1:0] SIZE_WORD_ALT = 2'b11;

   localparam int unsigned TIMEOUT_DEFAULT = 255;

   // Half needs addr[0]==0, word (and the 11 alias) needs addr[1:0]==0.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         SIZE_BYTE: return 1'b0;
         SIZE_HALF: return lane[0];
         default:   return |lane;
      endcase
   endfunction

   // Replicate right-justified store data onto every lane of the bus word.
   function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] data);
      case (size)
         SIZE_BYTE: return {4{data[7:0]}};
         SIZE_HALF: return {2{data[15:0]}};
         default:   return data;
      endcase
   endfunction

   // Little-endian byte enables for the addressed lane(s).
   function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         SIZE_BYTE: return 4'b0001 << lane;
         SIZE_HALF: return 4'b0011 << {lane[1], 1'b0};
         default:   return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and the memory (slave).
interface mem_access_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/mem_load_align.sv
// Selects the addressed lane of a read word and sign/zero-extends it.
module mem_load_align
   import mips_mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        is_signed,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane pick followed by extension according to access size.
   always_comb begin
      case (addr_lo)
         2'b00:   byte_sel = rdata[7:0];
         2'b01:   byte_sel = rdata[15:8];
         2'b10:   byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         SIZE_BYTE: result = {{24{is_signed & byte_sel[7]}}, byte_sel};
         SIZE_HALF: result = {{16{is_signed & half_sel[15]}}, half_sel};
         default:   result = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory requests, stalls the pipeline while
// waiting, formats load data and flags misaligned or timed-out accesses.
module mem_access_stage
   import mips_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                MemReadM,
   input  logic                MemWriteM,
   input  logic [1:0]          MemSizeM,
   input  logic                MemSignedM,
   input  logic [31:0]         ALUOutM,
   input  logic [31:0]         WriteDataM,
   output logic [31:0]         MemOutM,
   output logic                StallM,
   output logic                AlignErrM,
   output logic                BusErrM,
   mem_access_stage_if.master  dmem
);

   localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

   mem_state_t  state;
   logic [CW-1:0] cnt;
   logic [1:0]  lane_q;
   logic [1:0]  size_q;
   logic        signed_q;
   logic        access;
   logic        misaligned;
   logic [31:0] load_data;

   assign access     = MemReadM | MemWriteM;
   assign misaligned = is_misaligned(MemSizeM, ALUOutM[1:0]);

   mem_load_align u_align (
      .rdata     (dmem.dmem_rdata),
      .addr_lo   (lane_q),
      .size      (size_q),
      .is_signed (signed_q),
      .result    (load_data)
   );

   // Stall while an access waits in IDLE or is outstanding; never during reset.
   always_comb begin
      StallM = 1'b0;
      if (!reset)
         StallM = ((state == IDLE) && access) || (state == BUSY);
   end

   // Access FSM with registered bus outputs, load result and error pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         cnt             <= '0;
         MemOutM         <= '0;
         AlignErrM       <= 1'b0;
         BusErrM         <= 1'b0;
         lane_q          <= '0;
         size_q          <= '0;
         signed_q        <= 1'b0;
         dmem.dmem_req   <= 1'b0;
         dmem.dmem_we    <= 1'b0;
         dmem.dmem_addr  <= '0;
         dmem.dmem_wdata <= '0;
         dmem.dmem_be    <= '0;
      end else begin
         AlignErrM <= 1'b0;
         BusErrM   <= 1'b0;
         case (state)
            IDLE: begin
               if (access) begin
                  if (misaligned) begin
                     state     <= DONE;
                     AlignErrM <= 1'b1;
                  end else begin
                     state           <= BUSY;
                     cnt             <= '0;
                     lane_q          <= ALUOutM[1:0];
                     size_q          <= MemSizeM;
                     signed_q        <= MemSignedM;
                     dmem.dmem_req   <= 1'b1;
                     dmem.dmem_we    <= MemWriteM;
                     dmem.dmem_addr  <= {ALUOutM[31:2], 2'b00};
                     dmem.dmem_wdata <= store_wdata(MemSizeM, WriteDataM);
                     dmem.dmem_be    <= store_be(MemSizeM, ALUOutM[1:0]);
                  end
               end
            end
            BUSY: begin
               // An ack in the final allowed cycle takes priority over the timeout.
               if (dmem.dmem_ack) begin
                  state         <= DONE;
                  dmem.dmem_req <= 1'b0;
                  if (!dmem.dmem_we)
                     MemOutM <= load_data;
               end else if (cnt == CNT_LAST) begin
                  state         <= DONE;
                  dmem.dmem_req <= 1'b0;
                  BusErrM       <= 1'b1;
                  MemOutM       <= '0;
                  cnt           <= cnt + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed vectors push expected bus
// requests and completions; two monitors pop and compare independently.
module tb_mem_access_stage;
   import mips_mem_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemReadM, MemWriteM, MemSignedM;
   logic [1:0]  MemSizeM;
   logic [31:0] ALUOutM, WriteDataM, MemOutM;
   logic        StallM, AlignErrM, BusErrM;

   mem_access_stage_if bus ();

   mem_access_stage #(.TIMEOUT(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .MemReadM   (MemReadM),
      .MemWriteM  (MemWriteM),
      .MemSizeM   (MemSizeM),
      .MemSignedM (MemSignedM),
      .ALUOutM    (ALUOutM),
      .WriteDataM (WriteDataM),
      .MemOutM    (MemOutM),
      .StallM     (StallM),
      .AlignErrM  (AlignErrM),
      .BusErrM    (BusErrM),
      .dmem       (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rd, wr;
      logic [1:0]  sz;
      logic        sg;
      logic [31:0] a, wd, rdata;
      int          waits;      // wait cycles before ack; -1 = never ack
      int          exp_stall;
      bit          exp_req;
      logic [31:0] exp_wdata;
      logic [3:0]  exp_be;
      logic [31:0] exp_out;
      logic        exp_ae, exp_berr;
   } vec_t;

   typedef struct {
      logic        we;
      logic [31:0] addr, wdata;
      logic [3:0]  be;
   } bus_t;

   typedef struct {
      logic [31:0] out;
      logic        ae, berr;
   } done_t;

   bus_t  bus_q[$];
   done_t done_q[$];
   vec_t  vecs[$];
   int    checks = 0;
   int    failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Bus monitor: new request is compared to the scoreboard, then held stable.
   initial begin
      bus_t        cur;
      logic        prev;
      logic        h_we;
      logic [31:0] h_addr, h_wdata;
      logic [3:0]  h_be;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (reset !== 1'b1 && bus.dmem_req === 1'b1) begin
            if (!prev) begin
               if (bus_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL bus_unexpected_req actual=1 required=0 addr=%h", bus.dmem_addr);
               end else begin
                  cur = bus_q.pop_front();
                  chk("bus_we", bus.dmem_we, cur.we);
                  chk("bus_addr", bus.dmem_addr, cur.addr);
                  if (cur.we) begin
                     chk("bus_wdata", bus.dmem_wdata, cur.wdata);
                     chk("bus_be", bus.dmem_be, cur.be);
                  end
               end
               h_we = bus.dmem_we; h_addr = bus.dmem_addr;
               h_wdata = bus.dmem_wdata; h_be = bus.dmem_be;
            end else begin
               chk("hold_we", bus.dmem_we, h_we);
               chk("hold_addr", bus.dmem_addr, h_addr);
               chk("hold_wdata", bus.dmem_wdata, h_wdata);
               chk("hold_be", bus.dmem_be, h_be);
               chk("busy_no_err", {AlignErrM, BusErrM}, 0);
            end
         end
         prev = bus.dmem_req;
      end
   end

   // Completion monitor: access present and not stalled means result is out.
   initial begin
      done_t d;
      forever begin
         @(negedge clk);
         if (reset === 1'b0 && (MemReadM | MemWriteM) === 1'b1 && StallM === 1'b0) begin
            if (done_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL done_unexpected actual=%h required=none", MemOutM);
            end else begin
               d = done_q.pop_front();
               chk("memout", MemOutM, d.out);
               chk("align_err", AlignErrM, d.ae);
               chk("bus_err", BusErrM, d.berr);
            end
         end
      end
   end

   task automatic run_op(input vec_t v);
      int  stall, busy;
      bit  done;
      if (v.exp_req) bus_q.push_back('{v.wr, {v.a[31:2], 2'b00}, v.exp_wdata, v.exp_be});
      done_q.push_back('{v.exp_out, v.exp_ae, v.exp_berr});
      @(posedge clk); #1;
      MemReadM = v.rd; MemWriteM = v.wr; MemSizeM = v.sz; MemSignedM = v.sg;
      ALUOutM = v.a; WriteDataM = v.wd; bus.dmem_ack = 1'b0; bus.dmem_rdata = v.rdata;
      stall = 0; busy = 0; done = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (StallM === 1'b1) stall++;
         if (bus.dmem_req === 1'b1) begin
            busy++;
            bus.dmem_ack = (v.waits >= 0 && busy == v.waits + 1);
         end else begin
            bus.dmem_ack = 1'b0;
         end
         if (StallM === 1'b0) begin
            done = 1;
            break;
         end
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL op_complete actual=stalled required=done addr=%h", v.a);
      end
      chk("stall_cycles", stall, v.exp_stall);
      // Idle cycle with a stray ack: must not stall, request, or change MemOutM.
      @(posedge clk); #1;
      MemReadM = 1'b0; MemWriteM = 1'b0; bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h5A5A5A5A;
      @(negedge clk);
      chk("idle_stall", StallM, 0);
      @(posedge clk); #1;
      bus.dmem_ack = 1'b0;
      @(negedge clk);
      chk("idle_hold", MemOutM, v.exp_out);
      chk("idle_req", bus.dmem_req, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // rd wr sz sg addr wd rdata waits stall req ewdata ebe out ae berr
      vecs.push_back('{1'b1,1'b0,2'b10,1'b0,32'h100,32'h0,32'hDEADBEEF,0,2,1'b1,32'h0,4'h0,32'hDEADBEEF,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b0,2'b00,1'b1,32'h103,32'h0,32'h80112233,1,3,1'b1,32'h0,4'h0,32'hFFFFFF80,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b0,2'b01,1'b0,32'h102,32'h0,32'h80112233,0,2,1'b1,32'h0,4'h0,32'h00008011,1'b0,1'b0});
      vecs.push_back('{1'b0,1'b1,2'b00,1'b0,32'h101,32'hAB,32'h0,3,5,1'b1,32'hABABABAB,4'b0010,32'h00008011,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b0,2'b10,1'b0,32'h102,32'h0,32'h11111111,-1,1,1'b0,32'h0,4'h0,32'h00008011,1'b1,1'b0});
      vecs.push_back('{1'b1,1'b0,2'b10,1'b0,32'h200,32'h0,32'h12345678,-1,5,1'b1,32'h0,4'h0,32'h0,1'b0,1'b1});
      vecs.push_back('{1'b1,1'b0,2'b10,1'b0,32'h204,32'h0,32'hCAFEF00D,3,5,1'b1,32'h0,4'h0,32'hCAFEF00D,1'b0,1'b0});
      vecs.push_back('{1'b0,1'b1,2'b01,1'b0,32'h106,32'h1234BEEF,32'h0,0,2,1'b1,32'hBEEFBEEF,4'b1100,32'hCAFEF00D,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b0,2'b01,1'b1,32'h106,32'h0,32'h80017FFF,0,2,1'b1,32'h0,4'h0,32'hFFFF8001,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b0,2'b00,1'b0,32'h101,32'h0,32'h0000F500,0,2,1'b1,32'h0,4'h0,32'h000000F5,1'b0,1'b0});
      vecs.push_back('{1'b0,1'b1,2'b01,1'b0,32'h103,32'h1234,32'h0,-1,1,1'b0,32'h0,4'h0,32'h000000F5,1'b1,1'b0});
      vecs.push_back('{1'b0,1'b1,2'b11,1'b0,32'h108,32'h01020304,32'h0,2,4,1'b1,32'h01020304,4'b1111,32'h000000F5,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b1,2'b10,1'b0,32'h10C,32'h55AA55AA,32'h99999999,0,2,1'b1,32'h55AA55AA,4'b1111,32'h000000F5,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b0,2'b11,1'b0,32'h10A,32'h0,32'h77777777,-1,1,1'b0,32'h0,4'h0,32'h000000F5,1'b1,1'b0});
      vecs.push_back('{1'b1,1'b0,2'b00,1'b1,32'h100,32'h0,32'h1234567F,0,2,1'b1,32'h0,4'h0,32'h0000007F,1'b0,1'b0});

      // Reset with an access pending: everything cleared, no stall.
      reset = 1'b1;
      MemReadM = 1'b1; MemWriteM = 1'b0; MemSizeM = 2'b10; MemSignedM = 1'b0;
      ALUOutM = 32'h100; WriteDataM = 32'h0;
      bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
      @(negedge clk);
      chk("rst_stall", StallM, 0);
      chk("rst_memout", MemOutM, 0);
      chk("rst_errs", {AlignErrM, BusErrM}, 0);
      chk("rst_req_we", {bus.dmem_req, bus.dmem_we}, 0);
      chk("rst_addr", bus.dmem_addr, 0);
      chk("rst_wdata", bus.dmem_wdata, 0);
      chk("rst_be", bus.dmem_be, 0);
      MemReadM = 1'b0;
      #2 reset = 1'b0;

      foreach (vecs[i]) run_op(vecs[i]);

      // Reset mid-BUSY: request drops without a clock edge; late ack ignored.
      bus_q.push_back('{1'b0, 32'h300, 32'h0, 4'h0});
      @(posedge clk); #1;
      MemReadM = 1'b1; MemWriteM = 1'b0; MemSizeM = 2'b10; ALUOutM = 32'h300;
      @(negedge clk);
      @(negedge clk);
      chk("mid_busy_req", bus.dmem_req, 1);
      #2 reset = 1'b1;
      #1;
      chk("async_req_drop", bus.dmem_req, 0);
      chk("async_stall", StallM, 0);
      chk("async_memout", MemOutM, 0);
      MemReadM = 1'b0;
      @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      @(negedge clk);
      bus.dmem_ack = 1'b0;
      chk("late_ack_memout", MemOutM, 0);
      chk("late_ack_req", bus.dmem_req, 0);
      chk("late_ack_stall", StallM, 0);

      chk("bus_q_drained", bus_q.size(), 0);
      chk("done_q_drained", done_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
